// File: rtl/openddr_pkg.sv
// Shared types for the OpenDDR command scheduler.
//   sched_cmd_t   : command encoding driven on cmd_type
//   sched_state_t : scheduler FSM states
package openddr_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6
  } sched_cmd_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_PRE_WAIT,
    ST_ACT,
    ST_RCD_WAIT,
    ST_ACCESS,
    ST_REF_PREA,
    ST_REF_PREA_WAIT,
    ST_REF,
    ST_RFC_WAIT
  } sched_state_t;

  // Width of the shared FSM wait timer (covers T_RFC-1 up to 1022).
  localparam int TMR_W = 10;

endpackage

// File: rtl/openddr_bank_tracker.sv
// Per-bank page state: open flag, open row and a saturating tRAS counter.
// Ports:
//   mck, mc_rst_b : clock, async active-low reset
//   act, act_row  : ACT is being registered for this bank (opens row, restarts tRAS)
//   close         : PRE/PREA/REF is being registered (bank closes)
//   is_open, row  : current page state
//   ras_ok        : a PRE registered now lands at least T_RAS cycles after the ACT
module openddr_bank_tracker #(
  parameter int ROW_WIDTH = 16,
  parameter int T_RAS     = 10
) (
  input  logic                 mck,
  input  logic                 mc_rst_b,
  input  logic                 act,
  input  logic [ROW_WIDTH-1:0] act_row,
  input  logic                 close,
  output logic                 is_open,
  output logic [ROW_WIDTH-1:0] row,
  output logic                 ras_ok
);

  localparam logic [7:0] RAS_SAT = 8'(T_RAS);

  logic [7:0] ras_cnt;

  // ras_cnt is 0 in the cycle the ACT is on the bus, so a PRE decided now
  // appears one cycle later: compare against T_RAS-1.
  assign ras_ok = (ras_cnt >= (RAS_SAT - 8'd1));

  always_ff @(posedge mck or negedge mc_rst_b) begin
    if (!mc_rst_b) begin
      is_open <= 1'b0;
      row     <= '0;
      ras_cnt <= '0;
    end else if (act) begin
      is_open <= 1'b1;
      row     <= act_row;
      ras_cnt <= '0;
    end else begin
      if (close) is_open <= 1'b0;
      if (ras_cnt != RAS_SAT) ras_cnt <= ras_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/openddr_cmd_sched.sv
// In-order DDR command scheduler with open-page policy and periodic refresh.
// Ports:
//   mck, mc_rst_b             : clock, async active-low reset
//   cfg_ref_en                : enables the refresh interval counter
//   req_*                     : request handshake and fields (bank/row/col, write)
//   cmd_valid/type/bank/addr  : registered single-cycle command strobe
//   ref_pending, ref_miss     : refresh owed / sticky missed-interval flag
//
// state            | meaning
// IDLE             | ready for a request, or starting refresh when one is owed
// PRE              | row conflict, waiting for tRAS of the target bank
// PRE_WAIT         | PRE issued, counting tRP
// ACT              | ACT on the bus, first cycle of tRCD
// RCD_WAIT         | counting remaining tRCD
// ACCESS           | RD/WR on the bus
// REF_PREA         | refresh owed, waiting for tRAS of every open bank
// REF_PREA_WAIT    | PREA issued, counting tRP
// REF              | REF on the bus
// RFC_WAIT         | counting tRFC
module openddr_cmd_sched
  import openddr_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int ROW_WIDTH = 16,
  parameter int COL_WIDTH = 10,
  parameter int T_RCD     = 4,
  parameter int T_RP      = 4,
  parameter int T_RAS     = 10,
  parameter int T_RFC     = 52,
  parameter int T_REFI    = 1560
) (
  input  logic                         mck,
  input  logic                         mc_rst_b,
  input  logic                         cfg_ref_en,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [$clog2(NUM_BANKS)-1:0] req_bank,
  input  logic [ROW_WIDTH-1:0]         req_row,
  input  logic [COL_WIDTH-1:0]         req_col,
  output logic                         cmd_valid,
  output logic [2:0]                   cmd_type,
  output logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  output logic [ROW_WIDTH-1:0]         cmd_addr,
  output logic                         ref_pending,
  output logic                         ref_miss
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam logic [TMR_W-1:0] RP_LD  = TMR_W'(T_RP - 1);
  localparam logic [TMR_W-1:0] RCD_LD = TMR_W'(T_RCD - 1);
  localparam logic [TMR_W-1:0] RFC_LD = TMR_W'(T_RFC - 1);
  localparam logic [15:0]      REFI_LAST = 16'(T_REFI - 1);

  sched_state_t         state;
  sched_cmd_t           issue;
  sched_cmd_t           cmd_q;
  logic [TMR_W-1:0]     tmr;
  logic [15:0]          ref_cnt;
  logic                 write_q;
  logic [BW-1:0]        bank_q;
  logic [ROW_WIDTH-1:0] row_q;
  logic [COL_WIDTH-1:0] col_q;

  logic [NUM_BANKS-1:0] b_open;
  logic [NUM_BANKS-1:0] b_ras_ok;
  logic [ROW_WIDTH-1:0] b_row [NUM_BANKS];

  logic                 idle, sel_write, sel_open, sel_hit, sel_ras_ok;
  logic                 any_open, all_ras_ok, wrap;
  logic [BW-1:0]        sel_bank;
  logic [ROW_WIDTH-1:0] sel_row;
  logic [COL_WIDTH-1:0] sel_col;

  // In IDLE the live request fields are used so a row hit can issue next cycle.
  assign idle       = (state == ST_IDLE);
  assign sel_bank   = idle ? req_bank  : bank_q;
  assign sel_row    = idle ? req_row   : row_q;
  assign sel_col    = idle ? req_col   : col_q;
  assign sel_write  = idle ? req_write : write_q;
  assign sel_open   = b_open[sel_bank];
  assign sel_hit    = sel_open && (b_row[sel_bank] == sel_row);
  assign sel_ras_ok = b_ras_ok[sel_bank];
  assign any_open   = |b_open;
  assign all_ras_ok = &(~b_open | b_ras_ok);

  assign req_ready  = mc_rst_b & idle & ~ref_pending;
  assign cmd_type   = cmd_q;

  // Command legal to register this cycle given state and bank timing.
  always_comb begin
    issue = CMD_NOP;
    unique case (state)
      ST_IDLE: begin
        if (ref_pending) begin
          if (!any_open)       issue = CMD_REF;
          else if (all_ras_ok) issue = CMD_PREA;
        end else if (req_valid) begin
          if (sel_hit)         issue = sel_write ? CMD_WR : CMD_RD;
          else if (!sel_open)  issue = CMD_ACT;
          else if (sel_ras_ok) issue = CMD_PRE;
        end
      end
      ST_PRE:                 if (sel_ras_ok)   issue = CMD_PRE;
      ST_PRE_WAIT:            if (tmr == '0)    issue = CMD_ACT;
      ST_ACT, ST_RCD_WAIT:    if (tmr == '0)    issue = sel_write ? CMD_WR : CMD_RD;
      ST_REF_PREA:            if (all_ras_ok)   issue = CMD_PREA;
      ST_REF_PREA_WAIT:       if (tmr == '0)    issue = CMD_REF;
      default:                issue = CMD_NOP;
    endcase
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    openddr_bank_tracker #(
      .ROW_WIDTH(ROW_WIDTH),
      .T_RAS    (T_RAS)
    ) u_bank (
      .mck     (mck),
      .mc_rst_b(mc_rst_b),
      .act     ((issue == CMD_ACT) && (sel_bank == BW'(g))),
      .act_row (sel_row),
      .close   (((issue == CMD_PRE) && (sel_bank == BW'(g))) ||
                (issue == CMD_PREA) || (issue == CMD_REF)),
      .is_open (b_open[g]),
      .row     (b_row[g]),
      .ras_ok  (b_ras_ok[g])
    );
  end

  always_ff @(posedge mck or negedge mc_rst_b) begin
    if (!mc_rst_b) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      write_q   <= 1'b0;
      bank_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      cmd_valid <= 1'b0;
      cmd_q     <= CMD_NOP;
      cmd_bank  <= '0;
      cmd_addr  <= '0;
    end else begin
      cmd_valid <= (issue != CMD_NOP);
      cmd_q     <= issue;
      cmd_bank  <= (issue inside {CMD_ACT, CMD_RD, CMD_WR, CMD_PRE}) ? sel_bank : '0;
      case (issue)
        CMD_ACT:        cmd_addr <= sel_row;
        CMD_RD, CMD_WR: cmd_addr <= ROW_WIDTH'(sel_col);
        default:        cmd_addr <= '0;
      endcase

      case (state)
        ST_IDLE: begin
          if (ref_pending) begin
            if (issue == CMD_REF) begin
              state <= ST_REF;
            end else if (issue == CMD_PREA) begin
              state <= ST_REF_PREA_WAIT;
              tmr   <= RP_LD;
            end else begin
              state <= ST_REF_PREA;
            end
          end else if (req_valid) begin
            write_q <= req_write;
            bank_q  <= req_bank;
            row_q   <= req_row;
            col_q   <= req_col;
            case (issue)
              CMD_RD, CMD_WR: state <= ST_ACCESS;
              CMD_ACT: begin
                state <= ST_ACT;
                tmr   <= RCD_LD;
              end
              CMD_PRE: begin
                state <= ST_PRE_WAIT;
                tmr   <= RP_LD;
              end
              default: state <= ST_PRE;
            endcase
          end
        end
        ST_PRE: begin
          if (issue == CMD_PRE) begin
            state <= ST_PRE_WAIT;
            tmr   <= RP_LD;
          end
        end
        ST_PRE_WAIT: begin
          if (tmr == '0) begin
            state <= ST_ACT;
            tmr   <= RCD_LD;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_ACT, ST_RCD_WAIT: begin
          if (tmr == '0) begin
            state <= ST_ACCESS;
          end else begin
            state <= ST_RCD_WAIT;
            tmr   <= tmr - TMR_W'(1);
          end
        end
        ST_ACCESS: state <= ST_IDLE;
        ST_REF_PREA: begin
          if (issue == CMD_PREA) begin
            state <= ST_REF_PREA_WAIT;
            tmr   <= RP_LD;
          end
        end
        ST_REF_PREA_WAIT: begin
          if (tmr == '0) state <= ST_REF;
          else           tmr   <= tmr - TMR_W'(1);
        end
        ST_REF: begin
          state <= ST_RFC_WAIT;
          tmr   <= RFC_LD;
        end
        ST_RFC_WAIT: begin
          if (tmr == '0) state <= ST_IDLE;
          else           tmr   <= tmr - TMR_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A wrap coinciding with the REF that consumes the previous interval
  // re-arms ref_pending without counting as a miss.
  assign wrap = cfg_ref_en && (ref_cnt == REFI_LAST);

  always_ff @(posedge mck or negedge mc_rst_b) begin
    if (!mc_rst_b) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      ref_miss    <= 1'b0;
    end else begin
      if (cfg_ref_en) ref_cnt <= wrap ? '0 : ref_cnt + 16'd1;
      if (wrap)                      ref_pending <= 1'b1;
      else if (issue == CMD_REF)     ref_pending <= 1'b0;
      if (wrap && ref_pending && (issue != CMD_REF)) ref_miss <= 1'b1;
    end
  end

endmodule

// File: tb/tb_openddr_cmd_sched.sv
module tb_openddr_cmd_sched;

  localparam int RCD = 4, RP = 4, RAS = 10, RFC = 52, REFI = 20;
  localparam int C_ACT = 1, C_RD = 2, C_WR = 3, C_PRE = 4, C_PREA = 5, C_REF = 6;

  logic        mck = 1'b0;
  logic        mc_rst_b = 1'b0;
  logic        cfg_ref_en = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_bank = '0;
  logic [15:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [2:0]  cmd_bank;
  logic [15:0] cmd_addr;
  logic        ref_pending;
  logic        ref_miss;

  openddr_cmd_sched #(.T_REFI(REFI)) dut (
    .mck        (mck),
    .mc_rst_b   (mc_rst_b),
    .cfg_ref_en (cfg_ref_en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_bank   (req_bank),
    .req_row    (req_row),
    .req_col    (req_col),
    .cmd_valid  (cmd_valid),
    .cmd_type   (cmd_type),
    .cmd_bank   (cmd_bank),
    .cmd_addr   (cmd_addr),
    .ref_pending(ref_pending),
    .ref_miss   (ref_miss)
  );

  always #5 mck = ~mck;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: timestamps of scheduled commands derived from the timing rules.
  int          cyc;
  int          busy_until;
  int          ref_at;
  int          cnt_m;
  bit          pend_m, miss_m, acc_m;
  int          acc_cyc;
  int          n_ref_m, n_ref_obs;
  bit          open_m [8];
  logic [15:0] row_m [8];
  int          act_m [8];
  int          obs_cyc [8];
  logic [21:0] exp_cmd [int];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, want);
    end
  endtask

  function automatic void put(input int t, input int ty, input int b, input logic [15:0] a);
    exp_cmd[t] = {3'(ty), 3'(b), a};
  endfunction

  task automatic model_reset();
    cyc = 0; busy_until = 0; ref_at = -1; cnt_m = 0;
    pend_m = 0; miss_m = 0; acc_m = 0; n_ref_m = 0; n_ref_obs = 0;
    for (int i = 0; i < 8; i++) begin
      open_m[i] = 0; row_m[i] = '0; act_m[i] = -100; obs_cyc[i] = -1;
    end
    exp_cmd.delete();
  endtask

  task automatic model_decide(input logic v, input logic w, input logic [2:0] b,
                              input logic [15:0] r, input logic [9:0] col, input logic en);
    bit idle;
    bit wrap;
    int t, a, m;
    idle = (cyc >= busy_until);
    acc_m = 0;
    if (idle && pend_m) begin
      bit any;
      any = 0;
      t = cyc + 1;
      for (int i = 0; i < 8; i++)
        if (open_m[i]) begin
          any = 1;
          if (act_m[i] + RAS > t) t = act_m[i] + RAS;
        end
      if (any) begin
        put(t, C_PREA, 0, 16'h0);
        t = t + RP;
      end
      put(t, C_REF, 0, 16'h0);
      ref_at = t;
      n_ref_m++;
      busy_until = t + RFC + 1;
      for (int i = 0; i < 8; i++) open_m[i] = 0;
    end else if (idle && v) begin
      acc_m = 1;
      acc_cyc = cyc;
      if (open_m[b] && row_m[b] == r) begin
        m = cyc + 1;
      end else begin
        if (open_m[b]) begin
          t = cyc + 1;
          if (act_m[b] + RAS > t) t = act_m[b] + RAS;
          put(t, C_PRE, b, 16'h0);
          a = t + RP;
        end else begin
          a = cyc + 1;
        end
        put(a, C_ACT, b, r);
        act_m[b] = a; open_m[b] = 1; row_m[b] = r;
        m = a + RCD;
      end
      put(m, w ? C_WR : C_RD, b, {6'd0, col});
      busy_until = m + 1;
    end
    wrap = en && (cnt_m == REFI - 1);
    if (en) cnt_m = wrap ? 0 : cnt_m + 1;
    if (wrap) begin
      if (pend_m && ref_at != cyc + 1) miss_m = 1;
      pend_m = 1;
    end else if (ref_at == cyc + 1) begin
      pend_m = 0;
    end
  endtask

  task automatic check_cycle();
    logic [31:0] want;
    check_val("req_ready", req_ready, (cyc >= busy_until) && !pend_m);
    check_val("ref_pending", ref_pending, pend_m);
    check_val("ref_miss", ref_miss, miss_m);
    want = 0;
    if (exp_cmd.exists(cyc)) begin
      want = {9'd0, 1'b1, exp_cmd[cyc]};
      exp_cmd.delete(cyc);
    end
    check_val("cmd", {9'd0, cmd_valid, cmd_type, cmd_bank, cmd_addr}, want);
    if (cmd_valid) begin
      obs_cyc[cmd_type] = cyc;
      if (cmd_type == 3'(C_REF)) n_ref_obs++;
    end
  endtask

  task automatic step(input logic v, input logic w, input logic [2:0] b,
                      input logic [15:0] r, input logic [9:0] col, input logic en);
    req_valid = v; req_write = w; req_bank = b; req_row = r; req_col = col;
    cfg_ref_en = en;
    model_decide(v, w, b, r, col, en);
    @(posedge mck);
    @(negedge mck);
    cyc++;
    check_cycle();
  endtask

  task automatic idle_steps(input int n, input logic en);
    for (int k = 0; k < n; k++) step(0, 0, 3'd0, 16'h0, 10'h0, en);
  endtask

  task automatic send(input logic w, input logic [2:0] b, input logic [15:0] r,
                      input logic [9:0] col, input logic en);
    acc_m = 0;
    for (int k = 0; k < 300 && !acc_m; k++) step(1, w, b, r, col, en);
    if (!acc_m) check_val("send_timeout", 0, 1);
  endtask

  // Called at a negedge; releases reset at a later negedge so cycle 0 is sampled there.
  task automatic do_reset();
    mc_rst_b = 1'b0;
    req_valid = 0; req_write = 0; req_bank = '0; req_row = '0; req_col = '0;
    cfg_ref_en = 0;
    #1;
    check_val("rst_outs", {req_ready, cmd_valid, cmd_type, cmd_bank, cmd_addr, ref_pending, ref_miss}, 0);
    repeat (2) @(posedge mck);
    #1;
    check_val("rst_hold", {req_ready, cmd_valid, cmd_type, cmd_bank, cmd_addr, ref_pending, ref_miss}, 0);
    @(negedge mck);
    mc_rst_b = 1'b1;
    model_reset();
    #1;
    check_cycle();
  endtask

  initial begin
    int act0;
    model_reset();
    @(negedge mck);
    do_reset();

    // Closed-bank read accepted in cycle 10, then a row hit, then a row conflict.
    while (cyc < 10) idle_steps(1, 0);
    send(0, 3'd2, 16'h0010, 10'h020, 0);
    check_val("acc_cycle", acc_cyc, 10);
    idle_steps(6, 0);
    check_val("act_cycle", obs_cyc[C_ACT], 11);
    check_val("rd_cycle", obs_cyc[C_RD], 15);
    send(1, 3'd2, 16'h0010, 10'h044, 0);
    idle_steps(2, 0);
    check_val("hit_wr", obs_cyc[C_WR], acc_cyc + 1);
    check_val("hit_no_act", obs_cyc[C_ACT], 11);
    act0 = obs_cyc[C_ACT];
    send(1, 3'd2, 16'h0011, 10'h055, 0);
    idle_steps(20, 0);
    check_val("pre_gap", obs_cyc[C_PRE] - act0, RAS);
    check_val("act_gap", obs_cyc[C_ACT] - act0, RAS + RP);
    check_val("wr_gap", obs_cyc[C_WR] - act0, RAS + RP + RCD);

    // Refresh with bank 0 open, then an interval overrun during tRFC.
    do_reset();
    send(0, 3'd0, 16'h0007, 10'h001, 1);
    idle_steps(40, 1);
    check_val("prea_to_ref", obs_cyc[C_REF] - obs_cyc[C_PREA], RP);
    idle_steps(110, 1);
    check_val("miss_set", ref_miss, 1);
    check_val("ref_count", n_ref_obs, n_ref_m);

    // Reset while waiting on tRCD.
    do_reset();
    send(0, 3'd4, 16'h0123, 10'h010, 0);
    idle_steps(2, 0);
    do_reset();
    idle_steps(10, 0);
    check_val("no_rd_after_rst", obs_cyc[C_RD], -1);

    // Random traffic with refresh phases.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] b;
      b = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) b[2] = 1'b0;
      step($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), b,
           16'($urandom_range(0, 3)), 10'($urandom), ((i / 500) % 2) == 1);
    end
    idle_steps(80, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
